// File: rtl/floo_wide_link_serializer.sv
// Wide-flit to narrow-phit link serializer, LSB phit first, first/last framing, no inter-flit bubble.
// Optional even parity output on each phit when FLOO_SERDES_PARITY_EN is defined.
module floo_wide_link_serializer #(
   parameter int unsigned FlitWidth = 576,
   parameter int unsigned PhitWidth = 64,
   parameter int unsigned NumPhits  = (FlitWidth + PhitWidth - 1) / PhitWidth,
   parameter int unsigned CntWidth  = (NumPhits > 1) ? $clog2(NumPhits) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [FlitWidth-1:0] data_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [PhitWidth-1:0] phit_o,
   output logic                 first_o,
   output logic                 last_o
`ifdef FLOO_SERDES_PARITY_EN
   ,
   output logic                 parity_o
`endif
);

   localparam int unsigned BufWidth = NumPhits * PhitWidth;
   localparam logic [CntWidth-1:0] LastCnt = CntWidth'(NumPhits - 1);

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   state_e                             state_q, state_d;
   logic [CntWidth-1:0]                cnt_q, cnt_d;
   logic [NumPhits-1:0][PhitWidth-1:0] buf_q, buf_d;
   logic [BufWidth-1:0]                flit_ext;
   logic                               cnt_last;
   logic                               flit_accept;

   assign cnt_last = (cnt_q == LastCnt);

   // Ready may only rise combinationally with ready_i on the final phit, enabling back-to-back flits.
   assign ready_o = !rst_i && ((state_q == StIdle) || ((state_q == StSend) && cnt_last && ready_i));
   assign flit_accept = valid_i && ready_o;

   always_comb begin
      flit_ext = '0;
      flit_ext[FlitWidth-1:0] = data_i;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      if (flit_accept) begin
         buf_d   = flit_ext;
         cnt_d   = '0;
         state_d = StSend;
      end else if ((state_q == StSend) && ready_i) begin
         if (cnt_last) begin
            state_d = StIdle;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
      end
   end

   // Outputs derive from registered state only; no path from valid_i or ready_i.
   always_comb begin
      valid_o = 1'b0;
      phit_o  = '0;
      first_o = 1'b0;
      last_o  = 1'b0;
      if (state_q == StSend) begin
         valid_o = 1'b1;
         phit_o  = buf_q[cnt_q];
         first_o = (cnt_q == '0);
         last_o  = cnt_last;
      end
   end

`ifdef FLOO_SERDES_PARITY_EN
   // phit_o is zero when idle, so its XOR already yields 0 there.
   assign parity_o = ^phit_o;
`endif

endmodule

// File: tb/tb_floo_wide_link_serializer.sv
// Self-checking bench for floo_wide_link_serializer: directed sequences, a vector table on a
// 100/64 instance and randomized traffic against a phit-queue reference model.
module tb_floo_wide_link_serializer;

   localparam int unsigned FwA = 576;
   localparam int unsigned NpA = 9;
   localparam int unsigned FwB = 100;

   logic           clk = 1'b0;
   logic           rst = 1'b1;

   logic           va, ra, rdy_a, vo_a, fi_a, la_a, par_a;
   logic [FwA-1:0] da;
   logic [63:0]    ph_a;

   logic           vb, rb, rdy_b, vo_b, fi_b, la_b, par_b;
   logic [FwB-1:0] db;
   logic [63:0]    ph_b;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   floo_wide_link_serializer #(.FlitWidth(FwA), .PhitWidth(64)) u_dut_a (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (va),
      .ready_o (ra),
      .data_i  (da),
      .valid_o (vo_a),
      .ready_i (rdy_a),
      .phit_o  (ph_a),
      .first_o (fi_a),
      .last_o  (la_a)
`ifdef FLOO_SERDES_PARITY_EN
      ,
      .parity_o(par_a)
`endif
   );

   floo_wide_link_serializer #(.FlitWidth(FwB), .PhitWidth(64)) u_dut_b (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (vb),
      .ready_o (rb),
      .data_i  (db),
      .valid_o (vo_b),
      .ready_i (rdy_b),
      .phit_o  (ph_b),
      .first_o (fi_b),
      .last_o  (la_b)
`ifdef FLOO_SERDES_PARITY_EN
      ,
      .parity_o(par_b)
`endif
   );

`ifndef FLOO_SERDES_PARITY_EN
   assign par_a = 1'b0;
   assign par_b = 1'b0;
`endif

   typedef struct {
      logic           vld;
      logic           rdy;
      logic [FwB-1:0] data;
      logic           e_rdy;
      logic           e_vld;
      logic [63:0]    e_ph;
      logic           e_f;
      logic           e_l;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic av, input logic [63:0] aph, input logic af,
                          input logic al, input logic ar, input logic ap, input logic ev,
                          input logic [63:0] eph, input logic ef, input logic el, input logic er);
      chk({nm, "_valid"}, 64'(av), 64'(ev));
      chk({nm, "_phit"},  aph, eph);
      chk({nm, "_first"}, 64'(af), 64'(ef));
      chk({nm, "_last"},  64'(al), 64'(el));
      chk({nm, "_ready"}, 64'(ar), 64'(er));
`ifdef FLOO_SERDES_PARITY_EN
      chk({nm, "_parity"}, 64'(ap), 64'(ev ? ^eph : 1'b0));
`else
      if (ap !== 1'b0) chk({nm, "_parity_tie"}, 64'(ap), 64'd0);
`endif
   endtask

   task automatic chk_a(input string nm, input logic ev, input logic [63:0] eph, input logic ef,
                        input logic el, input logic er);
      chk_out(nm, vo_a, ph_a, fi_a, la_a, ra, par_a, ev, eph, ef, el, er);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] slice_a(input logic [FwA-1:0] d, input int k);
      return d[k*64 +: 64];
   endfunction

   function automatic logic [FwA-1:0] rand_flit();
      logic [FwA-1:0] f;
      for (int w = 0; w < FwA / 32; w++) f[w*32 +: 32] = $urandom;
      return f;
   endfunction

   // Accept one flit from idle and check all NpA phits with ready_i held high.
   task automatic run_flit_a(input string nm, input logic [FwA-1:0] f);
      va = 1'b1;
      da = f;
      #2;
      chk_a({nm, "_acc"}, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
      tick();
      va = 1'b0;
      for (int k = 0; k < NpA; k++) begin
         #2;
         chk_a($sformatf("%s_p%0d", nm, k), 1'b1, slice_a(f, k), k == 0, k == NpA - 1,
               k == NpA - 1);
         tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [FwA-1:0] f1, f2, f3, f4;
      logic [63:0]    q[$];
      logic           ev, ef, el, er, pop, push;
      logic [63:0]    eph;
      logic [FwB-1:0] all_ones, d2;

      all_ones = '1;
      d2       = {36'h5A5A5A5A5, 64'h0123456789ABCDEF};
      tbl[0] = '{1'b1, 1'b1, all_ones, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, '0, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 1'b0, '0, 1'b0, 1'b1, 64'h0000000FFFFFFFFF, 1'b0, 1'b1};
      tbl[3] = '{1'b1, 1'b1, d2, 1'b1, 1'b1, 64'h0000000FFFFFFFFF, 1'b0, 1'b1};
      tbl[4] = '{1'b0, 1'b1, '0, 1'b0, 1'b1, 64'h0123456789ABCDEF, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 1'b1, '0, 1'b1, 1'b1, 64'h00000005A5A5A5A5, 1'b0, 1'b1};
      tbl[6] = '{1'b0, 1'b1, '0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0};

      va = 1'b0; rdy_a = 1'b1; da = '0;
      vb = 1'b0; rdy_b = 1'b1; db = '0;
      rst = 1'b1;
      tick();

      // Reset: everything low, including ready_o.
      for (int i = 0; i < 3; i++) begin
         #2;
         chk_a($sformatf("rst%0d_a", i), 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
         chk_out($sformatf("rst%0d_b", i), vo_b, ph_b, fi_b, la_b, rb, par_b,
                 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      rst = 1'b0;
      #2;
      chk_out("release_b", vo_b, ph_b, fi_b, la_b, rb, par_b, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);

      // Single flit, byte i = i.
      for (int i = 0; i < FwA / 8; i++) f1[i*8 +: 8] = 8'(i);
      run_flit_a("single", f1);
      #2;
      chk_a("single_idle", 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);

      // Back-to-back: second flit taken on the first flit's last handshake.
      f1 = rand_flit();
      f2 = rand_flit();
      va = 1'b1;
      da = f1;
      #2;
      chk_a("b2b_acc", 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
      tick();
      da = f2;
      for (int k = 0; k < 2 * NpA; k++) begin
         #2;
         chk_a($sformatf("b2b_p%0d", k), 1'b1, slice_a((k < NpA) ? f1 : f2, k % NpA),
               (k % NpA) == 0, (k % NpA) == NpA - 1, (k % NpA) == NpA - 1);
         tick();
         if (k == NpA - 1) va = 1'b0;
      end
      #2;
      chk_a("b2b_idle", 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);

      // Backpressure for 5 cycles at cnt = 3.
      f3 = rand_flit();
      va = 1'b1;
      da = f3;
      #2;
      tick();
      va = 1'b0;
      for (int k = 0; k < NpA; k++) begin
         if (k == 3) begin
            rdy_a = 1'b0;
            for (int s = 0; s < 5; s++) begin
               #2;
               chk_a($sformatf("bp_hold%0d", s), 1'b1, slice_a(f3, 3), 1'b0, 1'b0, 1'b0);
               tick();
            end
            rdy_a = 1'b1;
         end
         #2;
         chk_a($sformatf("bp_p%0d", k), 1'b1, slice_a(f3, k), k == 0, k == NpA - 1, k == NpA - 1);
         tick();
      end

      // Reset asserted while phit 4 is on the link.
      f4 = rand_flit();
      va = 1'b1;
      da = f4;
      #2;
      tick();
      va = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #2;
         chk_a($sformatf("mr_p%0d", k), 1'b1, slice_a(f4, k), k == 0, 1'b0, 1'b0);
         if (k < 4) tick();
      end
      rst = 1'b1;
      tick();
      #2;
      chk_a("mr_inrst", 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      #2;
      chk_a("mr_after", 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
      run_flit_a("mr_fresh", rand_flit());

      // Vector table on the 100/64 instance: partial last phit, stall, back-to-back.
      for (int i = 0; i < 7; i++) begin
         vb    = tbl[i].vld;
         rdy_b = tbl[i].rdy;
         db    = tbl[i].data;
         #2;
         chk_out($sformatf("tbl%0d", i), vo_b, ph_b, fi_b, la_b, rb, par_b,
                 tbl[i].e_vld, tbl[i].e_ph, tbl[i].e_f, tbl[i].e_l, tbl[i].e_rdy);
         tick();
      end
      vb = 1'b0;

      // Random traffic: the model is a queue of phits still owed to the link.
      q.delete();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         rst   = ($urandom_range(0, 199) == 0);
         va    = ($urandom_range(0, 3) != 0);
         rdy_a = ($urandom_range(0, 3) != 0);
         da    = rand_flit();
         #2;
         ev  = (q.size() != 0);
         eph = ev ? q[0] : 64'd0;
         ef  = (q.size() == NpA);
         el  = (q.size() == 1);
         er  = !rst && ((q.size() == 0) || ((q.size() == 1) && rdy_a));
         chk_a($sformatf("rnd%0d", cyc), ev, eph, ef, el, er);
         pop  = ev && rdy_a;
         push = va && er;
         tick();
         if (rst) begin
            q.delete();
         end else begin
            if (pop) void'(q.pop_front());
            if (push) for (int k = 0; k < NpA; k++) q.push_back(slice_a(da, k));
         end
      end
      rst = 1'b0;
      va  = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/floo_wide_link_serializer.md
# floo_wide_link_serializer

Serializes wide-channel flits leaving a wide router output port onto a narrower physical link, one phit per handshake. Sits directly downstream of the wide router output (one instance per off-tile or long-haul wide port) and upstream of the link drivers. A matching deserializer at the far end reassembles flits using `first_o`/`last_o`. Throughput is one flit every `NumPhits` cycles, with no bubble between flits.

## Interface
Parameters:
- `FlitWidth`, default 576: width of the incoming wide flit in bits.
- `PhitWidth`, default 64: physical link width in bits; must satisfy 1 ≤ `PhitWidth` ≤ `FlitWidth`.
- `NumPhits`, derived as ceil(`FlitWidth`/`PhitWidth`): phits per flit; must be ≥ 2.
- `CntWidth`, derived as max(1, $clog2(`NumPhits`)): width of the phit counter.

Ports:
- `clk_i`, input, 1: the single clock.
- `rst_i`, input, 1: synchronous, active-high reset.
- `valid_i`, input, 1: flit valid from the router output.
- `ready_o`, output, 1: flit accepted when `valid_i && ready_o`.
- `data_i`, input, `FlitWidth`: flit payload.
- `valid_o`, output, 1: phit valid toward the link.
- `ready_i`, input, 1: link accepts the phit when `valid_o && ready_i`.
- `phit_o`, output, `PhitWidth`: current phit.
- `first_o`, output, 1: the current phit is phit 0 of its flit.
- `last_o`, output, 1: the current phit is phit `NumPhits`-1 of its flit.
- `parity_o`, output, 1: present only with `FLOO_SERDES_PARITY_EN`; even parity over `phit_o`.

## Operation
- Uses a two-state FSM: IDLE and SEND. The block holds a registered flit buffer of width `NumPhits`*`PhitWidth` and a phit counter `cnt` of width `CntWidth`.
- Flit accept: `ready_o` = (state==IDLE) || (state==SEND && `cnt`==`NumPhits`-1 && `ready_i`). When `rst_i` is high, `ready_o` is 0.
- On an accepted flit, the buffer loads `data_i`, zero-extended in the MSBs. `cnt` goes to 0 and state goes to SEND.
- In SEND:
  - `valid_o` = 1.
  - `phit_o` = buffer[`cnt`*`PhitWidth` +: `PhitWidth`], LSB phit first.
  - `first_o` = (`cnt`==0).
  - `last_o` = (`cnt`==`NumPhits`-1).
- Phit handshake with `cnt` < `NumPhits`-1: `cnt` increments.
- Phit handshake with `cnt`==`NumPhits`-1:
  - If `valid_i` is high in the same cycle, the new flit loads, `cnt` goes to 0 and state stays SEND (back-to-back operation).
  - Otherwise state goes to IDLE.
- While in SEND and `ready_i`=0, every output holds stable. The buffer is never modified mid-flit. `valid_o` is never retracted once asserted.
- `cnt` never exceeds `NumPhits`-1; there is no wrap-around past the last phit.
- In IDLE: `valid_o`=0; `phit_o`, `first_o` and `last_o` are 0.
- A reset asserted mid-flit discards the partial flit. The next state is IDLE, with no trailing phits and no `last_o` emitted. The deserializer handles link reset separately.

## Timing
- Reset values: `valid_o`=0, `phit_o`=0, `first_o`=0, `last_o`=0, `parity_o`=0. `ready_o`=0 while `rst_i` is high, and 1 in the first cycle after reset releases.
- Latency: a flit accepted in cycle t presents phit 0 in cycle t+1.
- With `ready_i` held at 1, phit k appears in cycle t+1+k.
- Sustained throughput is 1 phit per cycle. Input occupancy is one flit per `NumPhits` cycles.
- `ready_o` depends combinationally on `ready_i` and on state. `valid_o`, `phit_o`, `first_o` and `last_o` are registered-state-derived only, with no combinational path from `valid_i` or `ready_i`.

## Configuration
- Macro: `FLOO_SERDES_PARITY_EN`.
- Defined:
  - The `parity_o` port exists and equals ^`phit_o` while `valid_o` is high, and 0 otherwise.
  - Parity is computed from the buffer slice, so it adds no input-to-output combinational path.
- Undefined: the `parity_o` port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset then idle: hold `rst_i`=1 for 3 cycles, then release. Required: all outputs 0 during reset; `ready_o`=1 in the first cycle after release; `valid_o`=0.
- Single flit (`FlitWidth`=576, `PhitWidth`=64): send `data_i` with byte i = i, `ready_i`=1. Required:
  - 9 phits on consecutive cycles starting at t+1.
  - phit 0 = 0x0706050403020100.
  - `first_o` high on phit 0 only; `last_o` high on phit 8 only.
  - `ready_o` is 0 during phits 0–7.
- Partial last phit (`FlitWidth`=100, `PhitWidth`=64): send an all-ones flit. Required: phit 0 = 0xFFFFFFFFFFFFFFFF; phit 1 = 0x0000000FFFFFFFFF.
- Back-to-back: offer two flits with `valid_i` held high and `ready_i`=1. Required: 18 consecutive valid phits with no bubble; the second flit is accepted in the same cycle as the first flit's `last_o` handshake.
- Backpressure: drive `ready_i`=0 for 5 cycles at `cnt`=3. Required: `phit_o`, `first_o` and `last_o` stay stable and `valid_o` stays high; the flit completes with the correct phit order after release.
- Mid-flit reset: assert `rst_i` at `cnt`=4. Required: `valid_o`=0 the next cycle, no `last_o` ever seen for that flit, and a fresh flit afterwards starts at `first_o`=1. With `FLOO_SERDES_PARITY_EN` defined, also check that `parity_o` equals ^`phit_o` on every valid phit.
